// File: rtl/multi_width_stream_bram.sv
// Dual-port parameter memory: wide byte-enabled PS port A, plus an autonomous
// streaming reader on port B. Define MWSB_CYCLIC_EN to add cyclic/stop looping.
module multi_width_stream_bram #(
    parameter int ELEM_WIDTH   = 8,
    parameter int OUT_LANES    = 1,
    parameter int PORT_A_WIDTH = 32,
    parameter int BEAT_DEPTH   = 256,
    parameter int BEAT_WIDTH   = ELEM_WIDTH * OUT_LANES,
    parameter int RATIO        = PORT_A_WIDTH / BEAT_WIDTH,
    parameter int PORT_A_DEPTH = BEAT_DEPTH / RATIO,
    parameter int PORT_A_ADDR  = $clog2(PORT_A_DEPTH),
    parameter int BEAT_ADDR    = $clog2(BEAT_DEPTH),
    parameter int CNT_WIDTH    = BEAT_ADDR + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [PORT_A_WIDTH/8-1:0] wea,
    input  logic [PORT_A_ADDR-1:0]    addra,
    input  logic [PORT_A_WIDTH-1:0]   dina,
    output logic [PORT_A_WIDTH-1:0]   douta,
`ifdef MWSB_CYCLIC_EN
    input  logic                      cyclic,
    input  logic                      stop,
`endif
    input  logic                      start,
    input  logic [BEAT_ADDR-1:0]      start_addr,
    input  logic [CNT_WIDTH-1:0]      beat_count,
    output logic                      busy,
    output logic                      done,
    output logic [BEAT_WIDTH-1:0]     m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast
);

    localparam int LOG2R = $clog2(RATIO);
    localparam int SW    = (LOG2R > 0) ? LOG2R : 1;
    localparam logic [SW-1:0] LAST_SLICE = SW'(RATIO - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    logic [PORT_A_WIDTH-1:0] mem [PORT_A_DEPTH];
    logic [PORT_A_WIDTH-1:0] douta_q;
    logic [PORT_A_WIDTH-1:0] rdata_q;
    logic [PORT_A_WIDTH-1:0] buf_q [2];

    state_t                 state_q, state_d;
    logic [SW-1:0]          start_slice_q, start_slice_d;
    logic [PORT_A_ADDR-1:0] start_word_q, start_word_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   words_pass_q, words_pass_d;
    logic [PORT_A_ADDR-1:0] fetch_addr_q, fetch_addr_d;
    logic [CNT_WIDTH-1:0]   words_left_q, words_left_d;
    logic                   first_fetch_q, first_fetch_d;
    logic                   pend_q, pend_d;
    logic                   pend_first_q, pend_first_d;
    logic [CNT_WIDTH-1:0]   beats_left_q, beats_left_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [SW-1:0]          slice_q [2];
    logic [SW-1:0]          slice_d [2];

    logic [SW-1:0]          req_slice;
    logic [PORT_A_ADDR-1:0] req_word;
    logic [CNT_WIDTH:0]     req_sum;
    logic [CNT_WIDTH-1:0]   req_words;
    logic [SW-1:0]          head_slice;
    logic [2:0]             occ;
    logic                   last_beat, xfer, pop, issue, cont, refetch;

    // Port A: read-first, byte-granular writes
    always_ff @(posedge clk) begin
        if (ena) begin
            for (int i = 0; i < PORT_A_WIDTH / 8; i++) begin
                if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   douta_q <= '0;
        else if (ena) douta_q <= mem[addra];
    end

    assign douta = douta_q;

    // Port B read and word buffer fill
    always_ff @(posedge clk) begin
        if (issue)  rdata_q         <= mem[fetch_addr_q];
        if (pend_q) buf_q[wr_ptr_q] <= rdata_q;
    end

    assign req_slice = SW'(start_addr & BEAT_ADDR'(RATIO - 1));
    assign req_word  = PORT_A_ADDR'(start_addr >> LOG2R);
    assign req_sum   = (CNT_WIDTH+1)'(beat_count) + (CNT_WIDTH+1)'(req_slice)
                     + (CNT_WIDTH+1)'(RATIO - 1);
    assign req_words = CNT_WIDTH'(req_sum >> LOG2R);

    assign head_slice = slice_q[rd_ptr_q];
    assign m_tvalid   = (state_q == FETCH) && (cnt_q != 2'd0);
    assign last_beat  = (beats_left_q == CNT_WIDTH'(1));
    assign xfer       = m_tvalid && m_tready;
    assign pop        = xfer && ((head_slice == LAST_SLICE) || last_beat);
    // A slot freed by this cycle's pop may be refilled at once, which keeps
    // one beat per cycle going even when each word holds a single beat.
    assign occ        = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop};
    assign issue      = (state_q == FETCH) && (words_left_q != '0) && (occ < 3'd2);

    assign m_tdata = m_tvalid ? buf_q[rd_ptr_q][head_slice*BEAT_WIDTH +: BEAT_WIDTH] : '0;
    assign m_tlast = m_tvalid && last_beat;
    assign busy    = (state_q == FETCH);

`ifdef MWSB_CYCLIC_EN
    logic cyclic_q, stop_q, wrap_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyclic_q    <= 1'b0;
            stop_q      <= 1'b0;
            wrap_done_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                cyclic_q <= cyclic;
                stop_q   <= 1'b0;
            end else if (state_q == FETCH && stop) begin
                stop_q <= 1'b1;
            end
            wrap_done_q <= xfer && last_beat && cont;
        end
    end

    // Prefetch of the next pass may overshoot a stop; DONE discards it.
    assign refetch = cyclic_q && !stop_q;
    assign cont    = cyclic_q && !stop_q && !stop;
    assign done    = (state_q == DONE) || wrap_done_q;
`else
    assign refetch = 1'b0;
    assign cont    = 1'b0;
    assign done    = (state_q == DONE);
`endif

    always_comb begin
        state_d       = state_q;
        start_slice_d = start_slice_q;
        start_word_d  = start_word_q;
        count_d       = count_q;
        words_pass_d  = words_pass_q;
        fetch_addr_d  = fetch_addr_q;
        words_left_d  = words_left_q;
        first_fetch_d = first_fetch_q;
        beats_left_d  = beats_left_q;
        pend_d        = issue;
        pend_first_d  = first_fetch_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        cnt_d         = cnt_q;
        slice_d       = slice_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Zero-length requests still pass through FETCH for one cycle.
                    state_d       = FETCH;
                    start_slice_d = req_slice;
                    start_word_d  = req_word;
                    count_d       = beat_count;
                    words_pass_d  = req_words;
                    fetch_addr_d  = req_word;
                    words_left_d  = req_words;
                    first_fetch_d = 1'b1;
                    beats_left_d  = beat_count;
                end
            end
            FETCH: begin
                if (beats_left_q == '0) begin
                    state_d = DONE;
                end else if (xfer && last_beat) begin
                    if (cont) beats_left_d = count_q;
                    else      state_d      = DONE;
                end else if (xfer) begin
                    beats_left_d = beats_left_q - CNT_WIDTH'(1);
                end

                if (issue) begin
                    if (words_left_q == CNT_WIDTH'(1) && refetch) begin
                        fetch_addr_d  = start_word_q;
                        words_left_d  = words_pass_q;
                        first_fetch_d = 1'b1;
                    end else begin
                        fetch_addr_d  = fetch_addr_q + PORT_A_ADDR'(1);
                        words_left_d  = words_left_q - CNT_WIDTH'(1);
                        first_fetch_d = 1'b0;
                    end
                end

                if (pend_q) begin
                    slice_d[wr_ptr_q] = pend_first_q ? start_slice_q : '0;
                    wr_ptr_d          = ~wr_ptr_q;
                end
                if (pop)       rd_ptr_d          = ~rd_ptr_q;
                else if (xfer) slice_d[rd_ptr_q] = head_slice + SW'(1);
                cnt_d = cnt_q + 2'(pend_q) - 2'(pop);
            end
            default: begin
                state_d  = IDLE;
                rd_ptr_d = 1'b0;
                wr_ptr_d = 1'b0;
                cnt_d    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            start_slice_q <= '0;
            start_word_q  <= '0;
            count_q       <= '0;
            words_pass_q  <= '0;
            fetch_addr_q  <= '0;
            words_left_q  <= '0;
            first_fetch_q <= 1'b0;
            pend_q        <= 1'b0;
            pend_first_q  <= 1'b0;
            beats_left_q  <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
            slice_q       <= '{default: '0};
        end else begin
            state_q       <= state_d;
            start_slice_q <= start_slice_d;
            start_word_q  <= start_word_d;
            count_q       <= count_d;
            words_pass_q  <= words_pass_d;
            fetch_addr_q  <= fetch_addr_d;
            words_left_q  <= words_left_d;
            first_fetch_q <= first_fetch_d;
            pend_q        <= pend_d;
            pend_first_q  <= pend_first_d;
            beats_left_q  <= beats_left_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            slice_q       <= slice_d;
        end
    end

endmodule

// File: tb/tb_multi_width_stream_bram.sv
// Directed bench: one 8-bit/1-lane instance and one 8-bit/2-lane/64-bit instance.
module tb_multi_width_stream_bram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ena1, ena2;
    logic [3:0]  wea1;
    logic [7:0]  wea2;
    logic [5:0]  addra1, addra2;
    logic [31:0] dina1, douta1;
    logic [63:0] dina2, douta2;
    logic        start1, start2;
    logic [7:0]  start_addr;
    logic [8:0]  beat_count;
    logic        m_tready;
    logic        busy1, done1, tvalid1, tlast1;
    logic        busy2, done2, tvalid2, tlast2;
    logic [7:0]  tdata1;
    logic [15:0] tdata2;

    multi_width_stream_bram u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena1), .wea(wea1), .addra(addra1),
        .dina(dina1), .douta(douta1), .start(start1), .start_addr(start_addr),
        .beat_count(beat_count), .busy(busy1), .done(done1), .m_tdata(tdata1),
        .m_tvalid(tvalid1), .m_tready(m_tready), .m_tlast(tlast1));

    multi_width_stream_bram #(.ELEM_WIDTH(8), .OUT_LANES(2), .PORT_A_WIDTH(64)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena2), .wea(wea2), .addra(addra2),
        .dina(dina2), .douta(douta2), .start(start2), .start_addr(start_addr),
        .beat_count(beat_count), .busy(busy2), .done(done2), .m_tdata(tdata2),
        .m_tvalid(tvalid2), .m_tready(m_tready), .m_tlast(tlast2));

    int sel;
    logic        busy, done, tvalid, tlast;
    logic [15:0] tdata;

    always_comb begin
        if (sel == 0) begin
            busy = busy1; done = done1; tvalid = tvalid1; tlast = tlast1; tdata = {8'h00, tdata1};
        end else begin
            busy = busy2; done = done2; tvalid = tvalid2; tlast = tlast2; tdata = tdata2;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input int s, input int b);
        if (s == 0) return 16'(b & 255);
        return {8'((2*b + 1) & 255), 8'((2*b) & 255)};
    endfunction

    typedef struct {
        int          sel;
        int          sa;
        int          cnt;
        int          bp;
        logic [15:0] first;
        logic [15:0] last_d;
    } vec_t;

    vec_t vecs [9];

    task automatic run_stream(input vec_t v, input int poke);
        logic [15:0] held_data, expd;
        logic        held, held_last;
        logic [3:0]  pat;
        int idx, k, bubbles, early_done, nlast, b;
        pat = 4'b1001;
        held = 1'b0; held_data = '0; held_last = 1'b0;
        idx = 0; bubbles = 0; early_done = 0; nlast = 0;
        sel = v.sel;
        @(posedge clk); #1;
        start_addr = 8'(v.sa); beat_count = 9'(v.cnt); m_tready = 1'b1;
        if (v.sel == 0) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        @(negedge clk); check("lat_c1_tvalid", tvalid, 1'b0);
        @(negedge clk); check("lat_c2_tvalid", tvalid, 1'b0);
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k == 0) check("lat_c3_tvalid", tvalid, 1'b1);
            if (poke != 0 && k == 2) begin
                start1 = 1'b1; start_addr = 8'd100; beat_count = 9'd3;
            end
            if (poke != 0 && k == 3) start1 = 1'b0;
            m_tready = (v.bp != 0) ? pat[k % 4] : 1'b1;
            if (done) early_done++;
            if (tvalid) begin
                if (held) begin
                    check("stall_hold_data", tdata, held_data);
                    check("stall_hold_last", tlast, held_last);
                end
                if (m_tready) begin
                    b = (v.sa + idx) % 256;
                    if (idx == 0)              expd = v.first;
                    else if (idx == v.cnt - 1) expd = v.last_d;
                    else                       expd = model(v.sel, b);
                    check("beat_data", tdata, expd);
                    check("beat_last", tlast, (idx == v.cnt - 1));
                    if (tlast) nlast++;
                    idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; held_data = tdata; held_last = tlast;
                end
            end else if (idx > 0) begin
                bubbles++;
            end
            if (idx == v.cnt) break;
        end
        check("beats_seen", idx, v.cnt);
        check("tlast_count", nlast, 1);
        check("early_done", early_done, 0);
        if (v.bp == 0) check("no_bubbles", bubbles, 0);
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("busy_after", busy, 1'b0);
        check("tvalid_after", tvalid, 1'b0);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vec_t rv;
        int acc;
        vecs[0] = '{0, 1,   6,   0, 16'h0001, 16'h0006};
        vecs[1] = '{0, 254, 4,   0, 16'h00FE, 16'h0001};
        vecs[2] = '{0, 0,   32,  1, 16'h0000, 16'h001F};
        vecs[3] = '{0, 255, 1,   0, 16'h00FF, 16'h00FF};
        vecs[4] = '{0, 5,   20,  1, 16'h0005, 16'h0018};
        vecs[5] = '{0, 0,   256, 0, 16'h0000, 16'h00FF};
        vecs[6] = '{1, 62,  8,   0, 16'h7D7C, 16'h8B8A};
        vecs[7] = '{1, 254, 4,   0, 16'hFDFC, 16'h0302};
        vecs[8] = '{1, 3,   10,  1, 16'h0706, 16'h1918};

        sel = 0;
        rst_n = 1'b0;
        ena1 = 0; wea1 = '0; addra1 = '0; dina1 = '0;
        ena2 = 0; wea2 = '0; addra2 = '0; dina2 = '0;
        start1 = 0; start2 = 0; start_addr = '0; beat_count = '0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", tvalid1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_tlast", tlast1, 1'b0);
        check("rst_tdata", tdata1, 8'h00);
        check("rst_douta", douta1, 32'h0);
        check("rst_tvalid2", tvalid2, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int w = 0; w < 64; w++) begin
            @(posedge clk); #1;
            ena1 = 1; wea1 = 4'hF; addra1 = 6'(w);
            dina1 = {8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)};
            ena2 = 1; wea2 = 8'hFF; addra2 = 6'(w);
            for (int e = 0; e < 8; e++) dina2[8*e +: 8] = 8'((8*w + e) & 255);
        end
        @(posedge clk); #1;
        ena1 = 1; wea1 = 4'b0101; addra1 = 6'd2; dina1 = 32'hAABBCCDD;
        ena2 = 1; wea2 = 8'h00; addra2 = 6'd15;
        @(posedge clk); #1;
        check("douta_read_first", douta1, 32'h0B0A0908);
        check("douta2_read", douta2, 64'h7F7E7D7C7B7A7978);
        wea1 = 4'b0000; ena2 = 0;
        @(posedge clk); #1;
        check("douta_byte_we", douta1, 32'h0BBB09DD);
        wea1 = 4'hF; dina1 = 32'h0B0A0908;
        @(posedge clk); #1;
        ena1 = 0; wea1 = '0;

        for (int i = 0; i < 9; i++) run_stream(vecs[i], 0);

        // zero-length stream
        sel = 0;
        @(posedge clk); #1;
        start1 = 1; start_addr = 8'd7; beat_count = 9'd0; m_tready = 1'b1;
        @(posedge clk); #1;
        start1 = 0;
        @(negedge clk);
        check("zero_c1_done", done, 1'b0);
        check("zero_c1_busy", busy, 1'b1);
        @(negedge clk);
        check("zero_c2_done", done, 1'b1);
        check("zero_c2_busy", busy, 1'b0);
        check("zero_c2_tvalid", tvalid, 1'b0);
        @(negedge clk);
        check("zero_c3_done", done, 1'b0);
        check("zero_c3_tvalid", tvalid, 1'b0);

        // start while busy is ignored
        rv = '{0, 10, 8, 0, 16'h000A, 16'h0011};
        run_stream(rv, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("ignored_start_tvalid", tvalid, 1'b0);
        end

        // reset mid-stream aborts, memory survives
        sel = 0; acc = 0;
        @(posedge clk); #1;
        start1 = 1; start_addr = 8'd20; beat_count = 9'd10; m_tready = 1'b1;
        @(posedge clk); #1;
        start1 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tvalid) begin
                if (acc == 5) break;
                acc++;
            end
        end
        check("abort_at_beat5", acc, 5);
        check("abort_beat5_data", tdata, 16'h0019);
        rst_n = 1'b0;
        #1;
        check("abort_tvalid", tvalid1, 1'b0);
        check("abort_busy", busy1, 1'b0);
        check("abort_done", done1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", done1, 1'b0);
        rv = '{0, 40, 5, 0, 16'h0028, 16'h002C};
        run_stream(rv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
